// File: rtl/kcpsmx3_inc.sv
// Shared definitions for the BRAM arbiter: lock-state encoding and requester count.
package kcpsmx3_inc;

    typedef enum logic [1:0] {ARB_IDLE, ARB_OWN0, ARB_OWN1} bram_arb_state_t;

    localparam int BRAM_ARB_PORTS = 2;

endpackage

// File: rtl/bram_arb_pick.sv
// Combinational winner selection for bram_arbiter, producing a one-hot grant.
// Ties in IDLE are round-robin when BRAM_ARB_RR_EN is defined, else port 0 has fixed priority.
module bram_arb_pick
    import kcpsmx3_inc::*;
(
    input  logic                      req0_i,
    input  logic                      req1_i,
    input  bram_arb_state_t           state_i,
`ifdef BRAM_ARB_RR_EN
    input  logic                      lastWin_i,
`endif
    output logic [BRAM_ARB_PORTS-1:0] gnt_o
);

    always_comb begin
        gnt_o = '0;
        case (state_i)
            ARB_OWN0: gnt_o[0] = req0_i;
            ARB_OWN1: gnt_o[1] = req1_i;
            ARB_IDLE: begin
                if (req0_i && req1_i) begin
`ifdef BRAM_ARB_RR_EN
                    // lastWin_i = 1 means port 1 won last, so port 0 takes this tie.
                    gnt_o[0] = lastWin_i;
                    gnt_o[1] = ~lastWin_i;
`else
                    gnt_o[0] = 1'b1;
`endif
                end else begin
                    gnt_o[0] = req0_i;
                    gnt_o[1] = req1_i;
                end
            end
            default: gnt_o = '0;
        endcase
    end

endmodule

// File: rtl/bram_arbiter.sv
// Two-port arbiter in front of a single-port blockram with a lock FSM for bursts.
// Optional round-robin tie-break is enabled with the BRAM_ARB_RR_EN macro.
module bram_arbiter
    import kcpsmx3_inc::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 10
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic             we0,
    input  logic             we1,
    input  logic             lock0,
    input  logic             lock1,
    input  logic [DEPTH-1:0] ad0,
    input  logic [DEPTH-1:0] ad1,
    input  logic [WIDTH-1:0] din0,
    input  logic [WIDTH-1:0] din1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             rvalid0,
    output logic             rvalid1,
    output logic [WIDTH-1:0] rdata0,
    output logic [WIDTH-1:0] rdata1,
    output logic             ram_en,
    output logic             ram_we,
    output logic [DEPTH-1:0] ram_ad,
    output logic [WIDTH-1:0] ram_din,
    input  logic [WIDTH-1:0] ram_dout
);

    bram_arb_state_t           state_q, state_d;
    logic [BRAM_ARB_PORTS-1:0] pick;
    logic [BRAM_ARB_PORTS-1:0] gnt;
    logic [DEPTH-1:0]          ad_q;
    logic [WIDTH-1:0]          din_q;
    logic                      rvalid0_q, rvalid1_q;

`ifdef BRAM_ARB_RR_EN
    logic lastWin_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lastWin_q <= 1'b1;
        end else if (|gnt) begin
            lastWin_q <= gnt[1];
        end
    end
`endif

    bram_arb_pick u_pick (
        .req0_i    (req0),
        .req1_i    (req1),
        .state_i   (state_q),
`ifdef BRAM_ARB_RR_EN
        .lastWin_i (lastWin_q),
`endif
        .gnt_o     (pick)
    );

    // Requesters may hold req high through reset; no command may reach the RAM then.
    assign gnt = pick & {BRAM_ARB_PORTS{rst_n}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: begin
                if (gnt[0] && lock0) begin
                    state_d = ARB_OWN0;
                end else if (gnt[1] && lock1) begin
                    state_d = ARB_OWN1;
                end
            end
            ARB_OWN0: if (!lock0) state_d = ARB_IDLE;
            ARB_OWN1: if (!lock1) state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    // Address and write data fall back to the held copy whenever nothing is granted.
    always_comb begin
        gnt0    = gnt[0];
        gnt1    = gnt[1];
        ram_en  = |gnt;
        ram_we  = 1'b0;
        ram_ad  = ad_q;
        ram_din = din_q;
        if (gnt[0]) begin
            ram_we  = we0;
            ram_ad  = ad0;
            ram_din = din0;
        end else if (gnt[1]) begin
            ram_we  = we1;
            ram_ad  = ad1;
            ram_din = din1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ad_q      <= '0;
            din_q     <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            ad_q      <= ram_ad;
            din_q     <= ram_din;
            rvalid0_q <= gnt[0] & ~we0;
            rvalid1_q <= gnt[1] & ~we1;
        end
    end

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = rvalid0_q ? ram_dout : '0;
    assign rdata1  = rvalid1_q ? ram_dout : '0;

endmodule
